// File: rtl/riscv_dbg_pkg.sv
// Shared types for the run-control / debug-access unit: host opcodes,
// controller states and the default data width.
package riscv_dbg_pkg;

   localparam int DBG_XLEN = 32;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_HALT   = 3'd1,
      OP_RESUME = 3'd2,
      OP_STEP   = 3'd3,
      OP_RDREG  = 3'd4,
      OP_RDINS  = 3'd5,
      OP_SETBP  = 3'd6,
      OP_CLRBP  = 3'd7
   } dbg_op_e;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_HALTED = 3'd1,
      ST_STEP   = 3'd2,
      ST_RDREG  = 3'd3,
      ST_RESP   = 3'd4
   } dbg_state_e;

endpackage

// File: rtl/riscv_debug_unit_if.sv
// Host-side command/response handshake of the debug unit. The host drives
// the master modport, the debug unit sits on the slave modport.
interface riscv_debug_unit_if import riscv_dbg_pkg::*; #(
   parameter int XLEN = DBG_XLEN,
   parameter int RA_W = 5
);

   logic            cmd_valid;
   logic            cmd_ready;
   dbg_op_e         cmd_op;
   logic [RA_W-1:0] cmd_idx;
   logic [XLEN-1:0] cmd_arg;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_idx, cmd_arg, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_idx, cmd_arg, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/riscv_dbg_bp_match.sv
// PC breakpoint slots: address/enable registers loaded by set/clear strobes
// and a combinational per-slot match vector against the decode PC.
module riscv_dbg_bp_match #(
   parameter int NUM_BP = 2,
   parameter int XLEN   = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_stb,
   input  logic              clr_stb,
   input  logic [IDX_W-1:0]  idx,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   core_pc,
   input  logic              step_mask,
   output logic [NUM_BP-1:0] match
);

   // Word-aligned compare: the two byte-offset bits never take part.
   localparam logic [XLEN-1:0] CMP_MASK = ~XLEN'(3);

   logic [XLEN-1:0]   bp_addr_q [NUM_BP];
   logic [XLEN-1:0]   bp_addr_d [NUM_BP];
   logic [NUM_BP-1:0] bp_en_q;
   logic [NUM_BP-1:0] bp_en_d;

   always_comb begin
      bp_addr_d = bp_addr_q;
      bp_en_d   = bp_en_q;
      for (int i = 0; i < NUM_BP; i++) begin
         if (idx == IDX_W'(i)) begin
            if (set_stb) begin
               bp_addr_d[i] = addr;
               bp_en_d[i]   = 1'b1;
            end else if (clr_stb) begin
               bp_en_d[i]   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
         bp_en_q <= '0;
      end else begin
         bp_addr_q <= bp_addr_d;
         bp_en_q   <= bp_en_d;
      end
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         match[i] = bp_en_q[i] & ~step_mask &
                    (((bp_addr_q[i] ^ core_pc) & CMP_MASK) == '0);
      end
   end

endmodule

// File: rtl/riscv_debug_unit.sv
// Run-control and debug-access unit between the core wrapper and a debug
// host: halt/resume/step, register and instruction read, PC breakpoints.
//
// state  | meaning
// RUN    | core free-running, breakpoints armed
// HALTED | core held, waiting for a host command
// STEP   | hold dropped for one cycle to advance one instruction
// RDREG  | regfile rs1 address overridden, read data captured at cycle end
// RESP   | response pending; ret_halt_q selects HALTED or RUN afterwards
module riscv_debug_unit import riscv_dbg_pkg::*; #(
   parameter int NUM_BP = 2,
   parameter int XLEN   = DBG_XLEN,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              Rst,
   riscv_debug_unit_if.slave dbg_if,
   input  logic [XLEN-1:0]   core_pc,
   input  logic [XLEN-1:0]   core_ins,
   output logic              core_hold,
   output logic              reg_sel,
   output logic [RA_W-1:0]   reg_addr,
   input  logic [XLEN-1:0]   reg_data,
   output logic              halted,
   output logic [NUM_BP-1:0] bp_hit
);

   dbg_state_e        state_q, state_d;
   logic              ret_halt_q, ret_halt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              core_hold_q, core_hold_d;
   logic              halted_q, halted_d;
   logic              reg_sel_q, reg_sel_d;
   logic [RA_W-1:0]   reg_addr_q, reg_addr_d;
   logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;

   logic              accept, idx_ok, in_halt, bp_set, bp_clr, step_mask, bp_any, hold_st;
   logic [NUM_BP-1:0] bp_match, run_match;

   assign step_mask = (state_q == ST_STEP);
   assign accept    = dbg_if.cmd_valid & cmd_ready_q;
   assign idx_ok    = int'(dbg_if.cmd_idx) < NUM_BP;
   assign in_halt   = (state_q == ST_HALTED);
   // Breakpoints only halt a free-running core, never one that is in RESP.
   assign run_match = (state_q == ST_RUN) ? bp_match : '0;
   assign bp_any    = |run_match;

   riscv_dbg_bp_match #(
      .NUM_BP (NUM_BP),
      .XLEN   (XLEN),
      .IDX_W  (RA_W)
   ) u_bp (
      .clk       (clk),
      .rst_n     (Rst),
      .set_stb   (bp_set),
      .clr_stb   (bp_clr),
      .idx       (dbg_if.cmd_idx),
      .addr      (dbg_if.cmd_arg),
      .core_pc   (core_pc),
      .step_mask (step_mask),
      .match     (bp_match)
   );

   always_comb begin
      state_d     = state_q;
      ret_halt_d  = ret_halt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      reg_addr_d  = reg_addr_q;
      bp_hit_d    = bp_hit_q;
      bp_set      = 1'b0;
      bp_clr      = 1'b0;

      unique case (state_q)
         ST_RUN, ST_HALTED: begin
            if (accept) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = '0;
               ret_halt_d  = in_halt | bp_any;
               if (bp_any) bp_hit_d = run_match;
               unique case (dbg_if.cmd_op)
                  OP_HALT: begin
                     ret_halt_d = 1'b1;
                     rsp_data_d = core_pc;
                  end
                  OP_RESUME: begin
                     if (in_halt) begin
                        ret_halt_d = 1'b0;
                        bp_hit_d   = '0;
                     end
                  end
                  OP_STEP: begin
                     if (in_halt) begin
                        state_d     = ST_STEP;
                        rsp_valid_d = 1'b0;
                     end else begin
                        rsp_err_d = 1'b1;
                     end
                  end
                  OP_RDREG: begin
                     if (in_halt) begin
                        state_d     = ST_RDREG;
                        rsp_valid_d = 1'b0;
                        reg_addr_d  = dbg_if.cmd_idx;
                     end else begin
                        rsp_err_d = 1'b1;
                     end
                  end
                  OP_RDINS: rsp_data_d = core_ins;
                  OP_SETBP: begin
                     bp_set    = idx_ok;
                     rsp_err_d = ~idx_ok;
                  end
                  OP_CLRBP: begin
                     bp_clr    = idx_ok;
                     rsp_err_d = ~idx_ok;
                  end
                  default: ;
               endcase
            end else if (bp_any) begin
               state_d  = ST_HALTED;
               bp_hit_d = run_match;
            end
         end
         ST_STEP, ST_RDREG: begin
            state_d     = ST_RESP;
            ret_halt_d  = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = (state_q == ST_STEP) ? core_pc : reg_data;
         end
         ST_RESP: begin
            if (dbg_if.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ret_halt_q ? ST_HALTED : ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      hold_st     = (state_d == ST_HALTED) || (state_d == ST_RDREG) ||
                    ((state_d == ST_RESP) && ret_halt_d);
      core_hold_d = hold_st;
      halted_d    = hold_st || (state_d == ST_STEP);
      cmd_ready_d = (state_d == ST_RUN) || (state_d == ST_HALTED);
      reg_sel_d   = (state_d == ST_RDREG);
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= ST_RUN;
         ret_halt_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         core_hold_q <= 1'b0;
         halted_q    <= 1'b0;
         reg_sel_q   <= 1'b0;
         reg_addr_q  <= '0;
         bp_hit_q    <= '0;
      end else begin
         state_q     <= state_d;
         ret_halt_q  <= ret_halt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         core_hold_q <= core_hold_d;
         halted_q    <= halted_d;
         reg_sel_q   <= reg_sel_d;
         reg_addr_q  <= reg_addr_d;
         bp_hit_q    <= bp_hit_d;
      end
   end

   assign dbg_if.cmd_ready = cmd_ready_q;
   assign dbg_if.rsp_valid = rsp_valid_q;
   assign dbg_if.rsp_data  = rsp_data_q;
   assign dbg_if.rsp_err   = rsp_err_q;
   assign core_hold        = core_hold_q;
   assign halted           = halted_q;
   assign reg_sel          = reg_sel_q;
   assign reg_addr         = reg_addr_q;
   assign bp_hit           = bp_hit_q;

endmodule

// File: tb/tb_riscv_debug_unit.sv
// Bench for riscv_debug_unit: directed run-control scenarios plus randomized
// halted-mode commands and breakpoint runs checked against a behavioural model.
module tb_riscv_debug_unit;
   import riscv_dbg_pkg::*;

   localparam int NUM_BP = 2;
   localparam int XLEN   = 32;
   localparam int RA_W   = 5;

   logic              clk = 1'b0;
   logic              Rst;
   logic [XLEN-1:0]   core_pc, core_ins, reg_data;
   logic              core_hold, reg_sel, halted;
   logic [RA_W-1:0]   reg_addr;
   logic [NUM_BP-1:0] bp_hit;
   logic [XLEN-1:0]   rf [32];

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural breakpoint table as the host believes it to be.
   logic              m_en   [NUM_BP];
   logic [XLEN-1:0]   m_addr [NUM_BP];

   always #5 clk = ~clk;

   riscv_debug_unit_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

   assign reg_data = rf[reg_addr];

   riscv_debug_unit #(.NUM_BP(NUM_BP), .XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk       (clk),
      .Rst       (Rst),
      .dbg_if    (bus),
      .core_pc   (core_pc),
      .core_ins  (core_ins),
      .core_hold (core_hold),
      .reg_sel   (reg_sel),
      .reg_addr  (reg_addr),
      .reg_data  (reg_data),
      .halted    (halted),
      .bp_hit    (bp_hit)
   );

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [NUM_BP-1:0] model_hits(input logic [31:0] pc);
      logic [NUM_BP-1:0] v = '0;
      for (int i = 0; i < NUM_BP; i++)
         if (m_en[i] && (m_addr[i][31:2] == pc[31:2])) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] first_halt(input logic [31:0] start);
      logic [31:0] pc = start;
      for (int k = 0; k < 400; k++) begin
         if (model_hits(pc) != '0) return pc;
         pc = pc + 32'd4;
      end
      return 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Simple core: decode PC advances by one word every cycle the hold is low.
   task automatic tick;
      @(posedge clk);
      #1;
      if (!core_hold) core_pc = core_pc + 32'd4;
      core_ins = ins_of(core_pc);
   endtask

   task automatic do_cmd(input string tag, input dbg_op_e op, input logic [4:0] idx,
                         input logic [31:0] arg, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_lat, input int dly,
                         output int hold_low, output int rsel, output logic [4:0] rsel_addr);
      int n, lat;
      hold_low  = 0;
      rsel      = 0;
      rsel_addr = '0;
      bus.cmd_op    = op;
      bus.cmd_idx   = idx;
      bus.cmd_arg   = arg;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
      if (bus.cmd_ready !== 1'b1) begin
         chk({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
         bus.cmd_valid = 1'b0;
         return;
      end
      tick();
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         if (!core_hold) hold_low++;
         if (reg_sel) begin rsel++; rsel_addr = reg_addr; end
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (bus.rsp_valid !== 1'b1) return;
      chk({tag, "_data"}, bus.rsp_data, exp_data);
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
      for (int k = 0; k < dly; k++) begin
         tick();
         chk({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({tag, "_stall_data"}, bus.rsp_data, exp_data);
         chk({tag, "_stall_ready"}, 32'(bus.cmd_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hl, rs, n, sel;
      logic [4:0]  ra, idx;
      logic [31:0] exp_pc, tgt, arg, ed;
      logic        ee;
      int          el, dly;
      dbg_op_e     op;

      Rst = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_idx   = '0;
      bus.cmd_arg   = '0;
      bus.rsp_ready = 1'b0;
      core_pc  = '0;
      core_ins = ins_of('0);
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[5] = 32'hDEAD_BEEF;
      for (int i = 0; i < NUM_BP; i++) begin m_en[i] = 1'b0; m_addr[i] = '0; end

      // Reset values
      repeat (3) tick();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_halted",    32'(halted),        32'd0);
      chk("rst_hold",      32'(core_hold),     32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data",  bus.rsp_data,       32'd0);
      chk("rst_bp_hit",    32'(bp_hit),        32'd0);
      chk("rst_reg_sel",   32'(reg_sel),       32'd0);
      Rst = 1'b1;
      core_pc  = '0;
      core_ins = ins_of('0);

      // Breakpoint at 0x40 with the core running
      do_cmd("setbp0", OP_SETBP, 5'd0, 32'h40, 32'd0, 1'b0, 1, 0, hl, rs, ra);
      m_en[0] = 1'b1; m_addr[0] = 32'h40;
      exp_pc = first_halt(core_pc);
      n = 0;
      while (!halted && n < 60) begin tick(); n++; end
      chk("bp0_halted", 32'(halted), 32'd1);
      chk("bp0_pc", core_pc, exp_pc);
      chk("bp0_hit", 32'(bp_hit), 32'b01);
      chk("bp0_hold", 32'(core_hold), 32'd1);

      // Single step off the breakpoint
      do_cmd("step", OP_STEP, 5'd0, 32'd0, core_pc + 32'd4, 1'b0, 2, 0, hl, rs, ra);
      chk("step_hold_low", 32'(hl), 32'd1);
      chk("step_halted", 32'(halted), 32'd1);

      do_cmd("resume", OP_RESUME, 5'd0, 32'd0, 32'd0, 1'b0, 1, 0, hl, rs, ra);
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_bp_hit", 32'(bp_hit), 32'd0);
      chk("resume_hold", 32'(core_hold), 32'd0);

      // Host halt from RUN
      do_cmd("halt", OP_HALT, 5'd0, 32'd0, core_pc, 1'b0, 1, 0, hl, rs, ra);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_hold", 32'(core_hold), 32'd1);

      do_cmd("rdreg5", OP_RDREG, 5'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0, hl, rs, ra);
      chk("rdreg5_sel_cycles", 32'(rs), 32'd1);
      chk("rdreg5_addr", 32'(ra), 32'd5);

      do_cmd("rdins_halted", OP_RDINS, 5'd0, 32'd0, ins_of(core_pc), 1'b0, 1, 0, hl, rs, ra);

      do_cmd("resume2", OP_RESUME, 5'd0, 32'd0, 32'd0, 1'b0, 1, 0, hl, rs, ra);
      do_cmd("rdreg_run", OP_RDREG, 5'd5, 32'd0, 32'd0, 1'b1, 1, 0, hl, rs, ra);
      chk("rdreg_run_sel", 32'(rs), 32'd0);
      chk("rdreg_run_halted", 32'(halted), 32'd0);
      do_cmd("step_run", OP_STEP, 5'd0, 32'd0, 32'd0, 1'b1, 1, 0, hl, rs, ra);
      do_cmd("rdins_run", OP_RDINS, 5'd0, 32'd0, ins_of(core_pc), 1'b0, 1, 1, hl, rs, ra);

      // Out-of-range slot with a stalled response
      do_cmd("setbp3", OP_SETBP, 5'd3, core_pc + 32'h20, 32'd0, 1'b1, 1, 5, hl, rs, ra);
      repeat (30) tick();
      chk("setbp3_no_halt", 32'(halted), 32'd0);

      // Breakpoint match in the same cycle as a HALT accept
      tgt = core_pc + 32'd24;
      do_cmd("setbp1", OP_SETBP, 5'd1, tgt, 32'd0, 1'b0, 1, 0, hl, rs, ra);
      m_en[1] = 1'b1; m_addr[1] = tgt;
      n = 0;
      while (core_pc != tgt && n < 20) begin tick(); n++; end
      do_cmd("halt_bp", OP_HALT, 5'd0, 32'd0, tgt, 1'b0, 1, 0, hl, rs, ra);
      chk("halt_bp_hit", 32'(bp_hit), 32'b10);
      chk("halt_bp_halted", 32'(halted), 32'd1);
      chk("halt_bp_ready", 32'(bus.cmd_ready), 32'd1);

      // Randomized halted-mode commands followed by a breakpoint run
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 8; j++) begin
            sel = $urandom_range(0, 6);
            dly = $urandom_range(0, 3);
            arg = $urandom;
            idx = 5'($urandom_range(0, 31));
            ed = 32'd0; ee = 1'b0; el = 1;
            case (sel)
               0: op = OP_NOP;
               1: begin op = OP_HALT; ed = core_pc; end
               2: begin op = OP_STEP; ed = core_pc + 32'd4; el = 2; end
               3: begin op = OP_RDREG; ed = rf[idx]; el = 2; end
               4: begin op = OP_RDINS; ed = ins_of(core_pc); end
               5: begin
                  op  = OP_SETBP;
                  idx = 5'($urandom_range(0, 3));
                  if ($urandom_range(0, 1) == 1)
                     arg = core_pc + 32'($urandom_range(0, 300)) * 4 + 32'($urandom_range(0, 3));
                  ee = (int'(idx) >= NUM_BP);
               end
               default: begin
                  op  = OP_CLRBP;
                  idx = 5'($urandom_range(0, 3));
                  ee  = (int'(idx) >= NUM_BP);
               end
            endcase
            do_cmd("rand_cmd", op, idx, arg, ed, ee, el, dly, hl, rs, ra);
            if (op == OP_SETBP && !ee) begin m_en[idx] = 1'b1; m_addr[idx] = arg; end
            if (op == OP_CLRBP && !ee) m_en[idx] = 1'b0;
            if (op == OP_RDREG) chk("rand_rdreg_addr", 32'(ra), 32'(idx));
         end
         idx = 5'($urandom_range(0, NUM_BP - 1));
         tgt = core_pc + 32'd8 + 32'($urandom_range(0, 20)) * 4 + 32'($urandom_range(0, 3));
         do_cmd("rand_settgt", OP_SETBP, idx, tgt, 32'd0, 1'b0, 1, 0, hl, rs, ra);
         m_en[idx] = 1'b1; m_addr[idx] = tgt;
         exp_pc = first_halt(core_pc + 32'd8);
         do_cmd("rand_resume", OP_RESUME, 5'd0, 32'd0, 32'd0, 1'b0, 1, 0, hl, rs, ra);
         n = 0;
         while (!halted && n < 120) begin tick(); n++; end
         chk("rand_bp_halted", 32'(halted), 32'd1);
         chk("rand_bp_pc", core_pc, exp_pc);
         chk("rand_bp_hit", 32'(bp_hit), 32'(model_hits(exp_pc)));
      end

      // Asynchronous reset while a register read is in flight
      bus.cmd_op    = OP_RDREG;
      bus.cmd_idx   = 5'd7;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk("arst_pre_sel", 32'(reg_sel), 32'd1);
      #3 Rst = 1'b0;
      #1;
      chk("arst_hold",      32'(core_hold),     32'd0);
      chk("arst_sel",       32'(reg_sel),       32'd0);
      chk("arst_halted",    32'(halted),        32'd0);
      chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("arst_bp_hit",    32'(bp_hit),        32'd0);
      chk("arst_reg_addr",  32'(reg_addr),      32'd0);
      tick();
      tick();
      Rst = 1'b1;
      core_pc = '0;
      for (int i = 0; i < NUM_BP; i++) m_en[i] = 1'b0;
      repeat (25) tick();
      chk("arst_bp_cleared", 32'(halted), 32'(first_halt(32'd0) != 32'hFFFF_FFFF));
      chk("arst_rsp_lost", 32'(bus.rsp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_debug_unit.md
# riscv_debug_unit

Parametrised run-control and debug-access unit placed between the Mini-RISC-V core wrapper and an external debug host, typically bridged from UART. It replaces the static debug/prog level signals with a command/response handshake. Supported operations: halt, resume, single-step, register read, instruction read, and `NUM_BP` PC breakpoints. While the core is halted, the unit drives the pipeline hold and the register-file read-address override.

## Interface
Parameters:
- `NUM_BP`, 2 — number of PC breakpoint comparators (1–8).
- `XLEN`, 32 — data and PC width.
- `RA_W`, 5 — register address width.

Ports:
- `clk` in 1 — system clock.
- `Rst` in 1 — reset; asynchronous, active-low (0 = reset).
- `cmd_valid` in 1 — host command valid.
- `cmd_ready` out 1 — unit can accept a command.
- `cmd_op` in 3 — `dbg_op_e` opcode.
- `cmd_idx` in `RA_W` — register address, or breakpoint index.
- `cmd_arg` in `XLEN` — breakpoint address.
- `rsp_valid` out 1 — response valid.
- `rsp_ready` in 1 — host accepts the response.
- `rsp_data` out `XLEN` — response payload.
- `rsp_err` out 1 — command rejected.
- `core_pc` in `XLEN` — fetch-stage PC of the instruction in decode.
- `core_ins` in `XLEN` — instruction in decode.
- `core_hold` out 1 — stall the whole pipeline; replaces `dbg`.
- `reg_sel` out 1 — override the regfile rs1 address.
- `reg_addr` out `RA_W` — override address.
- `reg_data` in `XLEN` — regfile rs1 read data (combinational read).
- `halted` out 1 — core is halted.
- `bp_hit` out `NUM_BP` — breakpoint(s) that caused the last halt.

## Operation
- States (`dbg_state_e`): `RUN`, `HALTED`, `STEP`, `RDREG`, `RESP`.
- Opcodes: `NOP`=0, `HALT`=1, `RESUME`=2, `STEP`=3, `RDREG`=4, `RDINS`=5, `SETBP`=6, `CLRBP`=7.
- Only one command is outstanding at a time. `cmd_ready` = 1 only in `RUN` or `HALTED` with `rsp_valid`=0.
- Every accepted command produces exactly one response. `rsp_valid` holds, with stable data, until `rsp_ready`.
- `HALT`: `RUN`→`HALTED`. In `HALTED` it is a no-op. `rsp_data` = `core_pc` at halt, err=0.
- `RESUME`: `HALTED`→`RUN` and clears `bp_hit`. In `RUN` it is a no-op. `rsp_data`=0.
- `STEP`: valid only in `HALTED`.
  - `HALTED`→`STEP` drops `core_hold` for exactly one cycle, then returns to `HALTED`.
  - Breakpoints are masked during `STEP`, so a step can leave a breakpoint.
  - `rsp_data` = new `core_pc`.
  - Issued in `RUN`: err=1, no state change.
- `RDREG`: valid only in `HALTED`.
  - `reg_sel`=1 and `reg_addr`=`cmd_idx` for one cycle (`RDREG` state). `reg_data` is captured at the end of that cycle.
  - Issued in `RUN`: err=1.
- `RDINS`: returns `core_ins` in any state.
- `SETBP`: writes address `cmd_arg` into slot `cmd_idx` and sets its enable. `CLRBP` clears the slot's enable.
  - `cmd_idx` ≥ `NUM_BP`: err=1, no write.
  - Breakpoint address bits [1:0] are ignored in the compare.
- Breakpoint match: in `RUN`, any enabled slot with address == `core_pc` → next cycle `HALTED`, `core_hold`=1, `bp_hit` = match vector (OR of all matches).
- `core_hold` = 1 in `HALTED`, `RDREG`, and `RESP`-while-halted; 0 otherwise.
- `halted` reports the run-control state independent of response state. `RESP` remembers whether to return to `RUN` or `HALTED`.

## Timing
- Reset values:
  - state `RUN`; `core_hold`=0, `halted`=0.
  - `cmd_ready`=1; `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `reg_sel`=0, `reg_addr`=0.
  - `bp_hit`=0; all breakpoint enables 0.
- Accept takes place in the cycle with `cmd_valid & cmd_ready`.
- Response latency from accept to `rsp_valid`:
  - 1 cycle for `HALT`, `RESUME`, `RDINS`, `SETBP`, `CLRBP`.
  - 2 cycles for `RDREG` and `STEP`.
- `core_hold` rises the cycle after `HALT` is accepted or a breakpoint matches.
- Breakpoint match and `HALT` accepted in the same cycle: halt once. `bp_hit` = matches, `rsp_data` = `core_pc`.
- `SETBP` matching the current `core_pc` takes effect from the next cycle.
- Asynchronous reset mid-command: the response is lost, the state is `RUN`, and the hold is released immediately.
- Response stall (`rsp_ready`=0) never changes the run state. No new breakpoint halt is taken while in `RESP` from `RUN`.

## Structure
- Package `riscv_dbg_pkg`: `dbg_op_e` (3-bit enum), `dbg_state_e`, and `DBG_XLEN` default.
- Sub-module `riscv_dbg_bp_match`, parametrised by `NUM_BP`/`XLEN`. It holds the breakpoint address and enable registers, loaded by set/clear strobes, and gives a combinational match vector masked by `enable & ~step_mask`.
- The top contains the FSM and the response register.
- At integration: `core_hold` ORs into `bus.dbg`, and `reg_sel` muxes `bus.adr_rs1`.

## Test plan
- Reset with `Rst`=0, then release → `cmd_ready`=1, `halted`=0, `core_hold`=0, `rsp_valid`=0, `bp_hit`=0.
- `SETBP` idx0 arg `0x00000040`; run with `core_pc` stepping by 4 → halt the cycle after `core_pc`=`0x40`, `bp_hit`=`2'b01`, `core_hold`=1.
- Halted at `0x40`, `STEP` → hold low exactly 1 cycle, no re-halt on `0x40`, `rsp_data`=`0x44`. Then `RESUME` → `halted`=0, `bp_hit`=0.
- Halted, `RDREG` idx 5 with `reg_data`=`0xDEADBEEF` → `reg_sel`=1 with `reg_addr`=5 for one cycle, `rsp_data`=`0xDEADBEEF`, err=0. Same command in `RUN` → err=1.
- `SETBP` idx 3 with `NUM_BP`=2 → err=1 and no breakpoint armed. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data stable, `cmd_ready`=0.
- Assert `Rst`=0 while in `RDREG` → outputs at reset values asynchronously; `core_hold`=0 before the next `clk` edge.
